hilo_div_unit: RTL
==================

Name: hilo_div_unit

Overview:
- Execute-stage companion that consumes the ALU's 64-bit multiply result ({y, y_lo}) and owns the architectural HI/LO registers.
- Serves MTHI and MTLO writes.
- Runs MIPS DIV/DIVU as an iterative one-bit-per-cycle restoring divider, raising a stall to the pipeline while busy.
- HI/LO outputs feed the MFHI/MFLO path in the next stage.

Parameters:
- WIDTH, 32, operand/register width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  cancel any in-flight division; no HI/LO write
- mul_we  in  1  write HI/LO from multiply result
- mul_hi  in  WIDTH  product upper half (ALU y)
- mul_lo  in  WIDTH  product lower half (ALU y_lo)
- mthi_we  in  1  write mt_data to HI
- mtlo_we  in  1  write mt_data to LO
- mt_data  in  WIDTH  MTHI/MTLO source
- div_start  in  1  start division (single-cycle request)
- div_signed  in  1  1 = DIV, 0 = DIVU
- div_a  in  WIDTH  dividend
- div_b  in  WIDTH  divisor
- hi_o  out  WIDTH  HI register
- lo_o  out  WIDTH  LO register
- div_busy  out  1  division in progress (state != IDLE)
- div_done  out  1  one-cycle pulse when the division result is written
- stall_o  out  1  combinational: div_start | div_busy

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - hi_o = 0, lo_o = 0.
  - State IDLE; div_busy = 0, div_done = 0.
  - Counter and operand registers cleared.
  - rst overrides everything, including mid-division; HI/LO go to 0.
- FSM states and transitions:
  - IDLE:
    - div_start → RUN, or FIN if div_b == 0.
    - Otherwise stay in IDLE.
  - RUN: one iteration per edge; after the WIDTH-th iteration → FIN.
  - FIN: next edge writes HI/LO, pulses div_done, and returns to IDLE.
  - flush (and rst=0) in RUN or FIN → IDLE next edge; HI/LO unchanged; no div_done.
- Start capture (edge E0, in IDLE with div_start=1):
  - Latch |div_a| and |div_b|. Magnitudes are taken only when div_signed=1; two's complement negation, with 0x80000000 staying 0x80000000 as an unsigned value.
  - Latch quotient sign = a[31]^b[31] and remainder sign = a[31] (both forced to 0 when unsigned).
  - Latch the raw div_a for the divide-by-zero case.
- Iteration:
  - Shift the {rem, quo} register left by 1.
  - Trial-subtract the divisor from rem at WIDTH+1 bits.
  - If there is no borrow, update rem and set quo[0] = 1.
  - Counter runs 0..WIDTH-1.
- Latency: HI/LO are written at edge E(WIDTH+1), i.e. E33 for WIDTH = 32.
  - div_busy = 1 from after E0 through E33.
  - div_done is high for exactly the cycle after E33.
- FIN fixup:
  - LO = quotient, negated if the quotient sign is set.
  - HI = remainder, negated if the remainder sign is set.
- Divide by zero:
  - IDLE → FIN at E0; E1 writes HI = raw div_a, LO = all ones.
  - div_done is pulsed after E1.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0. This falls out of the datapath with no special case.
- Writes in IDLE, when div_start=0:
  - mul_we has priority: HI = mul_hi, LO = mul_lo.
  - Otherwise mthi_we and mtlo_we apply independently; both may fire in the same cycle.
- Priority and ignored inputs:
  - div_start in IDLE beats any simultaneous write; the write is dropped.
  - In RUN/FIN, mul_we, mthi_we, mtlo_we and div_start are ignored.
  - The pipeline guarantees none of these arrive while stall_o is high.
- Outputs hi_o and lo_o are registered; there is no internal bypass. New values are visible the cycle after the write edge.

Decomposition:
- Shared package holds:
  - State encodings (IDLE=2'b00, RUN=2'b01, FIN=2'b10).
  - DIV_ITER = WIDTH.
  - Counter width $clog2(WIDTH)+1.
- One natural sub-module, div_core:
  - Contains the iterative restoring datapath: magnitude latch, shift/subtract register, counter, sign fixup.
  - Exposes start/flush/done/quotient/remainder.
- hilo_div_unit keeps the FSM glue, the HI/LO registers and the write priority.

Test Plan:
- Multiply write: mul_we=1, mul_hi=0x00000001, mul_lo=0x80000000 → next cycle hi_o=0x00000001, lo_o=0x80000000; stall_o=0 throughout.
- Unsigned division: DIVU 100/7 → div_busy high 33 cycles; div_done single pulse; LO=14, HI=2; stall_o=1 from the start cycle until busy drops.
- Signed division: DIV -7/2 (0xFFFFFFF9 / 0x00000002) → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU a=5, b=0 → div_done after 1 cycle of busy; HI=5, LO=0xFFFFFFFF.
- Flush and reset: preload HI=0xAAAA, LO=0x5555, then flush on iteration 10 of 100/7 → busy drops next edge, HI/LO still 0xAAAA/0x5555, no div_done. Repeat with rst instead of flush → HI=LO=0, busy=0.
- Priority: div_start and mul_we asserted in the same cycle → the mul write is dropped and the division result lands. mthi_we and mtlo_we together with mt_data=0x1234 → HI=LO=0x1234.

Source files
------------

// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register and iterative divider unit.
package hilo_div_unit_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DIV_ITER  = WIDTH_DEF;
  localparam int CNT_W     = $clog2(DIV_ITER) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } div_state_e;

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Restoring divider datapath: operand magnitudes, shift/subtract register,
// iteration counter and final sign fixup (divide-by-zero handled here too).
module hilo_div_unit_div_core
  import hilo_div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_ITER,
  parameter int CW    = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH:0]   rem_ext_s, trial_s;

  // Next-state for the divider registers: load on start, one iteration per step.
  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    raw_a_d = raw_a_q;
    cnt_d   = cnt_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    dbz_d   = dbz_q;

    // The most negative value negates to itself, which is its correct magnitude as unsigned.
    a_mag_s = (is_signed && a[WIDTH-1]) ? ({WIDTH{1'b0}} - a) : a;
    b_mag_s = (is_signed && b[WIDTH-1]) ? ({WIDTH{1'b0}} - b) : b;

    // Carry the bit shifted out of rem so the trial subtract never loses it.
    rem_ext_s = {rem_q, quo_q[WIDTH-1]};
    trial_s   = rem_ext_s - {1'b0, dvs_q};

    if (start) begin
      rem_d   = {WIDTH{1'b0}};
      quo_d   = a_mag_s;
      dvs_d   = b_mag_s;
      raw_a_d = a;
      cnt_d   = {CW{1'b0}};
      qsign_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      rsign_d = is_signed & a[WIDTH-1];
      dbz_d   = (b == {WIDTH{1'b0}});
    end else if (flush) begin
      cnt_d = {CW{1'b0}};
    end else if (step) begin
      if (!trial_s[WIDTH]) begin
        rem_d = trial_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = rem_ext_s[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider register bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      raw_a_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      raw_a_q <= raw_a_d;
      cnt_q   <= cnt_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      dbz_q   <= dbz_d;
    end
  end

  // Result view: sign fixup, or the architectural divide-by-zero values.
  always_comb begin
    done = step && (cnt_q == LAST_CNT);
    if (dbz_q) begin
      quotient  = {WIDTH{1'b1}};
      remainder = raw_a_q;
    end else begin
      quotient  = qsign_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
      remainder = rsign_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Owns the HI/LO registers: multiply and MTHI/MTLO writes plus the
// sequencing of the iterative DIV/DIVU core, with a pipeline stall while busy.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             mul_we,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_a,
  input  logic [WIDTH-1:0] div_b,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_busy,
  output logic             div_done,
  output logic             stall_o
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             core_start_s, core_flush_s, core_step_s, core_done_s;
  logic [WIDTH-1:0] core_quo_s, core_rem_s;

  hilo_div_unit_div_core #(
    .WIDTH (WIDTH),
    .CW    ($clog2(WIDTH) + 1)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start_s),
    .flush     (core_flush_s),
    .step      (core_step_s),
    .is_signed (div_signed),
    .a         (div_a),
    .b         (div_b),
    .done      (core_done_s),
    .quotient  (core_quo_s),
    .remainder (core_rem_s)
  );

  // FSM next state, HI/LO write priority and core control.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    done_d       = 1'b0;
    core_start_s = 1'b0;
    core_flush_s = 1'b0;
    core_step_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (div_start) begin
          core_start_s = 1'b1;
          state_d      = (div_b == {WIDTH{1'b0}}) ? ST_FIN : ST_RUN;
        end else if (mul_we) begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end else begin
          hi_d = mthi_we ? mt_data : hi_q;
          lo_d = mtlo_we ? mt_data : lo_q;
        end
      end
      ST_RUN: begin
        if (flush) begin
          core_flush_s = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          core_step_s = 1'b1;
          state_d     = core_done_s ? ST_FIN : ST_RUN;
        end
      end
      ST_FIN: begin
        if (flush) begin
          core_flush_s = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          hi_d    = core_rem_s;
          lo_d    = core_quo_s;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign div_busy = (state_q != ST_IDLE);
  assign div_done = done_q;
  assign stall_o  = div_start | div_busy;

endmodule
